// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and constants for the MCS-to-Wishbone MMIO bridge.
//   bridge_state_t : bridge FSM states
//   BASE_HI        : IO_address[31:24] value selecting the MMIO window
//   ERR_DATA       : read data returned when a slot fails to acknowledge
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

  localparam logic [7:0]  BASE_HI  = 8'hC0;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mcs_wb_bridge.sv
// mcs_wb_bridge: turns MicroBlaze MCS I/O bus accesses into single-beat Wishbone master cycles
// for the MMIO slots. One transaction in flight at a time; an ACK timeout guards the CPU.
//
// Ports
//   CLK, RST                 clock, asynchronous active-low reset
//   IO_addr_strobe           MCS new-access pulse
//   IO_read_strobe           MCS read qualifier
//   IO_write_strobe          MCS write qualifier
//   IO_address               MCS byte address
//   IO_write_data            MCS write data
//   IO_read_data             read data, zero unless IO_ready is high
//   IO_ready                 one-cycle completion pulse
//   WB_CYC, WB_STB, WB_WE    Wishbone master controls
//   WB_ADDR, WB_DAT_O        Wishbone word address and write data
//   WB_DAT_I, WB_ACK         Wishbone read data and acknowledge
//   bus_err                  sticky timeout flag, cleared only by reset
module mcs_wb_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned ADDR_W   = 21,
  parameter logic [7:0]  BASE_HI  = mmio_pkg::BASE_HI,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = mmio_pkg::ERR_DATA
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IO_addr_strobe,
  input  logic              IO_read_strobe,
  input  logic              IO_write_strobe,
  input  logic [31:0]       IO_address,
  input  logic [31:0]       IO_write_data,
  output logic [31:0]       IO_read_data,
  output logic              IO_ready,
  output logic              WB_CYC,
  output logic              WB_STB,
  output logic              WB_WE,
  output logic [ADDR_W-1:0] WB_ADDR,
  output logic [31:0]       WB_DAT_O,
  input  logic [31:0]       WB_DAT_I,
  input  logic              WB_ACK,
  output logic              bus_err
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  bridge_state_t     state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              cyc_q, cyc_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic valid_req;
  logic in_window;
  logic unused_addr;

  // Exactly one of read/write must accompany the strobe; anything else is dropped.
  assign valid_req   = IO_addr_strobe & (IO_read_strobe ^ IO_write_strobe);
  assign in_window   = (IO_address[31:24] == BASE_HI);
  assign unused_addr = ^IO_address;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    cyc_d   = cyc_q;
    ready_d = ready_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (valid_req) begin
          addr_d  = IO_address[ADDR_W+1:2];
          wdata_d = IO_write_data;
          we_d    = IO_write_strobe;
          cnt_d   = '0;
          if (in_window) begin
            state_d = BUS;
            cyc_d   = 1'b1;
          end else begin
            // Unmapped address: answer immediately with zero, no bus cycle.
            state_d = RESP;
            rdata_d = '0;
            ready_d = 1'b1;
          end
        end
      end
      BUS: begin
        if (WB_ACK) begin
          // ACK takes priority over a timeout landing in the same cycle.
          state_d = RESP;
          rdata_d = we_q ? 32'h0 : WB_DAT_I;
          cyc_d   = 1'b0;
          ready_d = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = RESP;
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = '0;
        ready_d = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        ready_d = 1'b0;
        rdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      cyc_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      cyc_q   <= cyc_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign WB_CYC       = cyc_q;
  assign WB_STB       = cyc_q;
  assign WB_WE        = we_q;
  assign WB_ADDR      = addr_q;
  assign WB_DAT_O     = wdata_q;
  assign IO_ready     = ready_q;
  assign IO_read_data = rdata_q;
  assign bus_err      = err_q;

endmodule

// File: tb/tb_mcs_wb_bridge.sv
// tb_mcs_wb_bridge: scoreboard bench for mcs_wb_bridge with a registered-ACK slave model
// (timer at word 0/2, pattern data elsewhere, programmable ACK delay, ACK kill switch).
module tb_mcs_wb_bridge;

  localparam int unsigned AddrW   = 21;
  localparam int unsigned Timeout = 16;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             IO_addr_strobe = 1'b0;
  logic             IO_read_strobe = 1'b0;
  logic             IO_write_strobe = 1'b0;
  logic [31:0]      IO_address = '0;
  logic [31:0]      IO_write_data = '0;
  logic [31:0]      IO_read_data;
  logic             IO_ready;
  logic             WB_CYC;
  logic             WB_STB;
  logic             WB_WE;
  logic [AddrW-1:0] WB_ADDR;
  logic [31:0]      WB_DAT_O;
  logic [31:0]      WB_DAT_I;
  logic             WB_ACK;
  logic             bus_err;

  always #5 CLK = ~CLK;

  mcs_wb_bridge #(
    .ADDR_W  (AddrW),
    .BASE_HI (8'hC0),
    .TIMEOUT (Timeout),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .IO_addr_strobe (IO_addr_strobe),
    .IO_read_strobe (IO_read_strobe),
    .IO_write_strobe(IO_write_strobe),
    .IO_address     (IO_address),
    .IO_write_data  (IO_write_data),
    .IO_read_data   (IO_read_data),
    .IO_ready       (IO_ready),
    .WB_CYC         (WB_CYC),
    .WB_STB         (WB_STB),
    .WB_WE          (WB_WE),
    .WB_ADDR        (WB_ADDR),
    .WB_DAT_O       (WB_DAT_O),
    .WB_DAT_I       (WB_DAT_I),
    .WB_ACK         (WB_ACK),
    .bus_err        (bus_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
  endtask

  int cyc_n = 0;
  always @(posedge CLK) cyc_n <= cyc_n + 1;

  // Slave model: registered ACK after ack_delay wait cycles.
  logic             ack_q;
  logic [31:0]      dat_q;
  logic [31:0]      tmr_q;
  logic             tmr_en;
  int               wait_c;
  int               ack_delay = 0;
  bit               ack_dead = 1'b0;
  int               acc_n = 0;
  logic [AddrW-1:0] last_waddr = '0;
  logic [31:0]      last_wdata = '0;

  assign WB_ACK   = ack_q;
  assign WB_DAT_I = dat_q;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      tmr_q  <= '0;
      tmr_en <= 1'b0;
      wait_c <= 0;
    end else begin
      ack_q <= 1'b0;
      if (tmr_en) tmr_q <= tmr_q + 1;
      if (WB_CYC && WB_STB && !ack_q && !ack_dead) begin
        if (wait_c == ack_delay) begin
          ack_q  <= 1'b1;
          wait_c <= 0;
          acc_n  <= acc_n + 1;
          if (WB_WE) begin
            last_waddr <= WB_ADDR;
            last_wdata <= WB_DAT_O;
            if (WB_ADDR == 2) tmr_en <= WB_DAT_O[0];
          end else begin
            dat_q <= (WB_ADDR == 0) ? tmr_q : (32'h1000_0000 | 32'(WB_ADDR));
          end
        end else begin
          wait_c <= wait_c + 1;
        end
      end else if (!WB_CYC) begin
        wait_c <= 0;
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    int          lat;
    bit          rng;
    logic [31:0] lo;
    logic [31:0] hi;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   ready_n = 0;
  bit   cyc_seen = 1'b0;
  bit   prev_ack = 1'b0;

  function automatic exp_t mk(input logic [31:0] data, input int lat);
    exp_t e;
    e.data = data;
    e.lat  = lat;
    e.rng  = 1'b0;
    e.lo   = '0;
    e.hi   = '0;
    e.t0   = 0;
    return e;
  endfunction

  // Monitor: sample 1 time unit after each rising edge.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (RST) begin
      if (WB_CYC) cyc_seen = 1'b1;
      if (prev_ack) chk("cyc_after_ack", 32'(WB_CYC), 0);
      prev_ack = WB_ACK && WB_CYC;
      if (IO_ready) begin
        ready_n++;
        if (sb.size() == 0) begin
          chk("spurious_ready", 1, 0);
        end else begin
          e = sb.pop_front();
          if (e.rng) chk("rdata_range", 32'(IO_read_data >= e.lo && IO_read_data <= e.hi), 1);
          else chk("rdata", IO_read_data, e.data);
          chk("latency", cyc_n - e.t0, e.lat);
        end
      end else begin
        chk("rdata_idle_zero", IO_read_data, 0);
      end
    end else begin
      prev_ack = 1'b0;
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit push, input exp_t e);
    @(posedge CLK);
    #1;
    IO_addr_strobe  = 1'b1;
    IO_read_strobe  = rd;
    IO_write_strobe = wr;
    IO_address      = addr;
    IO_write_data   = wdata;
    e.t0 = cyc_n;
    if (push) sb.push_back(e);
    @(posedge CLK);
    #1;
    IO_addr_strobe  = 1'b0;
    IO_read_strobe  = 1'b0;
    IO_write_strobe = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge CLK);
    #2;
    if (sb.size() != 0) begin
      chk("resp_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   acc0;
    int   r0;

    // Reset state
    #12;
    chk("rst_cyc", 32'(WB_CYC), 0);
    chk("rst_stb", 32'(WB_STB), 0);
    chk("rst_we", 32'(WB_WE), 0);
    chk("rst_addr", 32'(WB_ADDR), 0);
    chk("rst_dato", WB_DAT_O, 0);
    chk("rst_ready", 32'(IO_ready), 0);
    chk("rst_rdata", IO_read_data, 0);
    chk("rst_err", 32'(bus_err), 0);
    @(negedge CLK);
    RST = 1'b1;

    // 1: start timer
    acc0 = acc_n;
    issue(1'b0, 1'b1, 32'hC000_0008, 32'h0000_0001, 1'b1, mk(32'h0, 3));
    wait_done();
    chk("t1_waddr", 32'(last_waddr), 2);
    chk("t1_wdata", last_wdata, 1);
    chk("t1_one_access", acc_n - acc0, 1);
    chk("t1_timer_on", 32'(tmr_en), 1);

    // 2: read timer count after ~100 cycles
    repeat (100) @(posedge CLK);
    e = mk(32'h0, 3);
    e.rng = 1'b1;
    e.lo  = 32'd100;
    e.hi  = 32'd115;
    issue(1'b1, 1'b0, 32'hC000_0000, 32'h0, 1'b1, e);
    wait_done();

    // 3: outside the window
    cyc_seen = 1'b0;
    acc0 = acc_n;
    issue(1'b1, 1'b0, 32'h4000_0000, 32'h0, 1'b1, mk(32'h0, 1));
    wait_done();
    chk("t3_no_cyc", 32'(cyc_seen), 0);
    chk("t3_no_access", acc_n - acc0, 0);

    // Plain mapped read
    issue(1'b1, 1'b0, 32'hC000_0014, 32'h0, 1'b1, mk(32'h1000_0005, 3));
    wait_done();

    // Both / neither qualifier: ignored
    cyc_seen = 1'b0;
    r0 = ready_n;
    issue(1'b1, 1'b1, 32'hC000_0018, 32'h0, 1'b0, mk(32'h0, 0));
    issue(1'b0, 1'b0, 32'hC000_0018, 32'h0, 1'b0, mk(32'h0, 0));
    repeat (6) @(posedge CLK);
    #2;
    chk("bad_qual_no_ready", ready_n - r0, 0);
    chk("bad_qual_no_cyc", 32'(cyc_seen), 0);

    // ACK in the final timeout cycle wins
    ack_delay = Timeout - 2;
    issue(1'b1, 1'b0, 32'hC000_001C, 32'h0, 1'b1, mk(32'h1000_0007, Timeout + 1));
    wait_done();
    chk("ack_wins_no_err", 32'(bus_err), 0);

    // 5: second strobe during BUS ignored
    ack_delay = 3;
    r0 = ready_n;
    acc0 = acc_n;
    issue(1'b1, 1'b0, 32'hC000_0010, 32'h0, 1'b1, mk(32'h1000_0004, 6));
    issue(1'b0, 1'b1, 32'hC000_0030, 32'h5555_AAAA, 1'b0, mk(32'h0, 0));
    chk("t5_cyc_busy", 32'(WB_CYC), 1);
    chk("t5_addr_held", 32'(WB_ADDR), 4);
    chk("t5_we_held", 32'(WB_WE), 0);
    wait_done();
    repeat (6) @(posedge CLK);
    #2;
    chk("t5_one_ready", ready_n - r0, 1);
    chk("t5_one_access", acc_n - acc0, 1);
    ack_delay = 0;

    // 4: dead slot timeout
    ack_dead = 1'b1;
    issue(1'b1, 1'b0, 32'hC000_0020, 32'h0, 1'b1, mk(32'hDEAD_BEEF, Timeout + 1));
    wait_done();
    chk("t4_err_set", 32'(bus_err), 1);
    ack_dead = 1'b0;
    issue(1'b1, 1'b0, 32'hC000_0024, 32'h0, 1'b1, mk(32'h1000_0009, 3));
    wait_done();
    chk("t4_err_sticky", 32'(bus_err), 1);

    // 6: reset in the middle of BUS
    ack_dead = 1'b1;
    issue(1'b1, 1'b0, 32'hC000_0028, 32'h0, 1'b0, mk(32'h0, 0));
    repeat (2) @(posedge CLK);
    #3;
    chk("t6_cyc_before", 32'(WB_CYC), 1);
    RST = 1'b0;
    #1;
    chk("t6_cyc_drop", 32'(WB_CYC), 0);
    chk("t6_stb_drop", 32'(WB_STB), 0);
    chk("t6_ready_low", 32'(IO_ready), 0);
    chk("t6_err_clear", 32'(bus_err), 0);
    sb.delete();
    ack_dead = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    issue(1'b1, 1'b0, 32'hC000_002C, 32'h0, 1'b1, mk(32'h1000_000B, 3));
    wait_done();
    chk("t6_err_after", 32'(bus_err), 0);

    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
